// File: rtl/instruction_fetch.sv
// Fetch stage: drives the ROM address from the PC and registers the returned word into IR.
// Optional NOP-delay wait compiled in with the FETCH_NOP_DELAY_EN macro.
`ifndef NOP
`define NOP 6'h00
`endif

module instruction_fetch #(
    parameter int                  ADDR_W   = 16,
    parameter int                  INSTR_W  = 30,
    parameter logic [ADDR_W-1:0]   RESET_PC = 16'd0
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic [ADDR_W-1:0]  oRomAddress,
    input  logic [INSTR_W-1:0] iRomInstruction,
    input  logic               iStall,
    input  logic               iRedirect,
    input  logic [ADDR_W-1:0]  iRedirectTarget,
    output logic [INSTR_W-1:0] oInstruction,
    output logic [ADDR_W-1:0]  oPC,
    output logic               oValid,
    output logic               oWaiting
);

    localparam logic [INSTR_W-1:0] NOP_WORD = {`NOP, {(INSTR_W-6){1'b0}}};
    localparam logic [ADDR_W-1:0]  PC_ONE   = 1;

    logic [ADDR_W-1:0]  r_pc,    w_pc;
    logic [INSTR_W-1:0] r_ir,    w_ir;
    logic [ADDR_W-1:0]  r_opc,   w_opc;
    logic               r_valid, w_valid;

`ifdef FETCH_NOP_DELAY_EN
    typedef enum logic {ST_RUN, ST_DELAY} state_t;
    state_t      r_state, w_state;
    logic [23:0] r_cnt,   w_cnt;
    // r_arm: a delay NOP was just issued; the next edge starts the countdown.
    logic        r_arm,   w_arm;
`endif

    always_comb begin
        w_pc    = r_pc;
        w_ir    = r_ir;
        w_opc   = r_opc;
        w_valid = r_valid;
`ifdef FETCH_NOP_DELAY_EN
        w_state = r_state;
        w_cnt   = r_cnt;
        w_arm   = r_arm;
`endif
        if (iRedirect) begin
            w_pc    = iRedirectTarget;
            w_ir    = NOP_WORD;
            w_valid = 1'b0;
`ifdef FETCH_NOP_DELAY_EN
            w_state = ST_RUN;
            w_cnt   = '0;
            w_arm   = 1'b0;
        end else if (r_state == ST_DELAY) begin
            w_valid = 1'b0;
            w_cnt   = r_cnt - 24'd1;
            if (r_cnt <= 24'd1) begin
                w_state = ST_RUN;
                w_cnt   = '0;
            end
        end else if (r_arm) begin
            w_state = ST_DELAY;
            w_cnt   = r_ir[23:0];
            w_valid = 1'b0;
            w_arm   = 1'b0;
`endif
        end else if (!iStall) begin
            w_ir    = iRomInstruction;
            w_opc   = r_pc;
            w_pc    = r_pc + PC_ONE;
            w_valid = 1'b1;
`ifdef FETCH_NOP_DELAY_EN
            w_arm   = (iRomInstruction[INSTR_W-1 -: 6] == `NOP) && (|iRomInstruction[23:0]);
`endif
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_pc    <= RESET_PC;
            r_ir    <= NOP_WORD;
            r_opc   <= '0;
            r_valid <= 1'b0;
`ifdef FETCH_NOP_DELAY_EN
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_arm   <= 1'b0;
`endif
        end else begin
            r_pc    <= w_pc;
            r_ir    <= w_ir;
            r_opc   <= w_opc;
            r_valid <= w_valid;
`ifdef FETCH_NOP_DELAY_EN
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_arm   <= w_arm;
`endif
        end
    end

    assign oRomAddress  = r_pc;
    assign oInstruction = r_ir;
    assign oPC          = r_opc;
    assign oValid       = r_valid;
`ifdef FETCH_NOP_DELAY_EN
    assign oWaiting     = (r_state == ST_DELAY);
`else
    assign oWaiting     = 1'b0;
`endif

endmodule
